sumres_serie: RTL and testbench
===============================

// Module: sumres_serie
// PURPOSE
//  Parametrised multi-cycle adder/subtractor, successor to the fixed 5-bit ripple subtractor.
//  Processes CHUNK bits per clock through a chain of sum1b cells and keeps the carry in a register between chunks.
//  Subtraction is A + ~B + 1; the +1 is injected as the initial carry.
//  Start/done handshake with operand latching; produces result plus carry/overflow/zero/negative flags for the ALU datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 2
//  CHUNK  1  bits processed per cycle; must divide WIDTH; N = WIDTH/CHUNK cycles per operation
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only while ready=1
//  op      in   1      0 = A+B, 1 = A-B
//  a       in   WIDTH  operand A (minuend); latched on accepted start
//  b       in   WIDTH  operand B (subtrahend); latched on accepted start
//  ready   out  1      high in IDLE; block accepts start
//  done    out  1      one-cycle pulse: result and flags valid
//  result  out  WIDTH  A+B or A-B, modulo 2^WIDTH
//  cout    out  1      final carry out; on subtract, 1 = no borrow (A >= B unsigned)
//  ovf     out  1      signed overflow = carry into MSB XOR carry out of MSB
//  zero    out  1      result == 0
//  neg     out  1      result[WIDTH-1]
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ready=1, done=0, result/cout/ovf/zero/neg=0, chunk counter=0.
//  States:
//   IDLE -> RUN   start=1: latch a, latch (op ? ~b : b), carry_reg=op, cnt=0
//   RUN  -> RUN   add the current CHUNK slice with carry_reg via CHUNK chained sum1b; write the sum slice
//                 into the shift/result register; update carry_reg; cnt++
//   RUN  -> DONE  after the Nth slice is processed; flags computed from the final sum
//   DONE -> IDLE  unconditionally after 1 cycle
//  Timing:
//   - done is high exactly N cycles after the edge that accepted start (N=8 for the 8/1 configuration).
//   - done is high for one cycle; ready is low in RUN and DONE.
//  Outputs: result and flags update only on the RUN->DONE edge, then hold until the next completed operation
//   or reset. Intermediate slices are never visible on result.
//  Overflow: ovf requires carry-in of bit WIDTH-1, taken from inside the last chunk (CHUNK>1) or from
//   carry_reg (CHUNK=1).
//  start while ready=0: ignored; no queuing; latched operands are unaffected.
//  a/b/op changing after acceptance: no effect on the operation in progress.
//  start held high continuously: a new operation is accepted in each IDLE cycle, i.e. one per N+2 cycles.
//  Reset mid-RUN: operation aborted, outputs cleared to reset values, no done pulse.
//  Widths: all arithmetic is modulo 2^WIDTH; the carry is the only extra bit.
// STRUCTURE
//  Shared package/include sumres_pkg.vh:
//   - OP_SUMA=1'b0, OP_RESTA=1'b1
//   - state encodings ST_IDLE/ST_RUN/ST_DONE (2 bits)
//  Sub-module: sum1b (existing full adder: A, B, Ci -> Sum, Cout), instantiated CHUNK times via generate,
//   carry chained.
//  Counter width: $clog2(N)+1.
// TESTING (WIDTH=8; run each with CHUNK=1 and CHUNK=4)
//  1. op=1 a=5 b=3 -> done after N cycles; result=0x02, cout=1, ovf=0, zero=0, neg=0.
//  2. op=1 a=3 b=5 -> result=0xFE, cout=0 (borrow), neg=1, ovf=0.
//  3. op=0 a=0x7F b=0x01 -> result=0x80, ovf=1, neg=1, cout=0.
//     op=1 a=0x80 b=0x01 -> result=0x7F, ovf=1, cout=1.
//  4. op=1 a=0x2A b=0x2A -> result=0x00, zero=1, cout=1.
//     op=0 a=0xFF b=0x01 -> result=0x00, zero=1, cout=1.
//  5. Second start plus changed a/b during RUN -> ignored; first result unchanged; exactly one done pulse.
//  6. Assert rst 2 cycles into RUN -> outputs 0, ready=1 immediately, no done.
//     New op=0 a=1 b=1 afterwards -> result=0x02.

Source files
------------

// File: rtl/sumres_serie_pkg.sv
// rtl/sumres_serie_pkg.sv - shared op codes and FSM states for the serial adder/subtractor
package sumres_serie_pkg;

  localparam logic OP_SUMA  = 1'b0;
  localparam logic OP_RESTA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sumres_serie_sum1b.sv
// rtl/sumres_serie_sum1b.sv - one-bit full adder cell (sum1b) used in the chunk carry chain
module sumres_serie_sum1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sumres_serie.sv
// rtl/sumres_serie.sv - multi-cycle adder/subtractor, CHUNK bits per clock with registered carry
module sumres_serie
  import sumres_serie_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, sum_nx;
  logic             carry_reg;
  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] s;
  logic             accept, last;

  assign accept = (state == ST_IDLE) && start;
  assign last   = (state == ST_RUN) && (cnt == LAST);
  assign ready  = (state == ST_IDLE);
  assign done   = (state == ST_DONE);

  // Carry chain across the current slice; c[CHUNK-1] is the carry into the slice MSB
  assign c[0] = carry_reg;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    sumres_serie_sum1b u_bit (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Sum slices enter at the top so after N slices the LSB slice has reached bit 0
  assign sum_nx = (acc >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (accept) begin
      a_sh      <= a;
      b_sh      <= (op == OP_SUMA) ? b : ~b;
      carry_reg <= (op == OP_RESTA);
      cnt       <= '0;
    end else if (state == ST_RUN) begin
      a_sh      <= a_sh >> CHUNK;
      b_sh      <= b_sh >> CHUNK;
      acc       <= sum_nx;
      carry_reg <= c[CHUNK];
      cnt       <= cnt + CW'(1);
      if (last) begin
        result <= sum_nx;
        cout   <= c[CHUNK];
        ovf    <= c[CHUNK] ^ c[CHUNK-1];
        zero   <= (sum_nx == '0);
        neg    <= sum_nx[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_sumres_serie.sv
// tb/tb_sumres_serie.sv - scoreboard bench for sumres_serie, WIDTH=8 with CHUNK=1 and CHUNK=4
module tb_sumres_serie;

  typedef struct packed {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       neg;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic       op    [2];
  logic [7:0] a     [2];
  logic [7:0] b     [2];
  logic       ready [2];
  logic       done  [2];
  logic [7:0] result[2];
  logic       cout  [2];
  logic       ovf   [2];
  logic       zero  [2];
  logic       neg   [2];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic prev_done[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sumres_serie #(.WIDTH(8), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[0]), .op(op[0]), .a(a[0]), .b(b[0]),
    .ready(ready[0]), .done(done[0]), .result(result[0]), .cout(cout[0]),
    .ovf(ovf[0]), .zero(zero[0]), .neg(neg[0])
  );

  sumres_serie #(.WIDTH(8), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start[1]), .op(op[1]), .a(a[1]), .b(b[1]),
    .ready(ready[1]), .done(done[1]), .result(result[1]), .cout(cout[1]),
    .ovf(ovf[1]), .zero(zero[1]), .neg(neg[1])
  );

  function automatic int nval(input int s);
    return (s == 0) ? 8 : 2;
  endfunction

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic o, input logic [7:0] x, input logic [7:0] y);
    exp_t        e;
    int unsigned ur;
    int          sr;
    if (o == 1'b0) begin
      ur     = int'(x) + int'(y);
      sr     = int'($signed(x)) + int'($signed(y));
      e.cout = (ur > 255);
    end else begin
      ur     = 256 + int'(x) - int'(y);
      sr     = int'($signed(x)) - int'($signed(y));
      e.cout = (x >= y);
    end
    e.res  = ur[7:0];
    e.ovf  = (sr > 127) || (sr < -128);
    e.zero = (e.res == 8'h00);
    e.neg  = e.res[7];
    e.due  = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic on_done(input int s);
    exp_t e;
    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
      n_chk++;
      $display("FAIL d%0d_unexpected_done: got done=1 expected no pulse at cycle %0d", s, cyc);
    end else begin
      if (s == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("d%0d_result", s),  32'(result[s]), 32'(e.res));
      chk($sformatf("d%0d_cout", s),    32'(cout[s]),   32'(e.cout));
      chk($sformatf("d%0d_ovf", s),     32'(ovf[s]),    32'(e.ovf));
      chk($sformatf("d%0d_zero", s),    32'(zero[s]),   32'(e.zero));
      chk($sformatf("d%0d_neg", s),     32'(neg[s]),    32'(e.neg));
      chk($sformatf("d%0d_latency", s), 32'(cyc),       32'(e.due));
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) prev_done[s] = 1'b0;
      else begin
        if (done[s]) begin
          on_done(s);
          chk($sformatf("d%0d_done_width", s), 32'(prev_done[s]), 32'd0);
          chk($sformatf("d%0d_ready_low", s), 32'(ready[s]), 32'd0);
        end
        prev_done[s] = done[s];
      end
    end
  end

  task automatic issue(input int s, input logic o, input logic [7:0] x, input logic [7:0] y,
                       input bit track);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!ready[s] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready[s]) chk($sformatf("d%0d_ready_timeout", s), 32'(ready[s]), 32'd1);
    op[s] = o; a[s] = x; b[s] = y; start[s] = 1'b1;
    @(posedge clk);
    #1;
    start[s] = 1'b0;
    e = model(o, x, y);
    e.due = cyc + nval(s);
    if (track) begin
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    // Operands must already be latched
    a[s] = 8'($urandom); b[s] = 8'($urandom); op[s] = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() + q1.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  logic [16:0] vec [6];

  initial begin
    vec = '{{1'b1, 8'h05, 8'h03}, {1'b1, 8'h03, 8'h05}, {1'b0, 8'h7F, 8'h01},
            {1'b1, 8'h80, 8'h01}, {1'b1, 8'h2A, 8'h2A}, {1'b0, 8'hFF, 8'h01}};
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; op[s] = 1'b0; a[s] = 8'h00; b[s] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("d%0d_rst_ready", s),  32'(ready[s]),  32'd1);
      chk($sformatf("d%0d_rst_done", s),   32'(done[s]),   32'd0);
      chk($sformatf("d%0d_rst_result", s), 32'(result[s]), 32'd0);
      chk($sformatf("d%0d_rst_flags", s),
          32'({cout[s], ovf[s], zero[s], neg[s]}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 6; v++) begin
        logic [16:0] t;
        t = vec[v];
        issue(s, t[16], t[15:8], t[7:0], 1'b1);
      end
      drain();

      // Start pulse with new operands while busy must be ignored
      issue(s, 1'b1, 8'h05, 8'h03, 1'b1);
      @(negedge clk);
      start[s] = 1'b1; op[s] = 1'b0; a[s] = 8'hC3; b[s] = 8'h11;
      @(negedge clk);
      start[s] = 1'b0;
      drain();
      repeat (nval(s) + 3) @(negedge clk);

      for (int r = 0; r < 30; r++)
        issue(s, 1'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      drain();

      // Abort mid-RUN: no done, outputs back to reset values
      issue(s, 1'b0, 8'h7F, 8'h01, 1'b0);
      repeat ((nval(s) > 2) ? 2 : 1) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk($sformatf("d%0d_abort_ready", s),  32'(ready[s]),  32'd1);
      chk($sformatf("d%0d_abort_done", s),   32'(done[s]),   32'd0);
      chk($sformatf("d%0d_abort_result", s), 32'(result[s]), 32'd0);
      chk($sformatf("d%0d_abort_flags", s),
          32'({cout[s], ovf[s], zero[s], neg[s]}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (nval(s) + 3) @(negedge clk);
      issue(s, 1'b0, 8'h01, 8'h01, 1'b1);
      drain();
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
